ckpt_allocator: RTL

- Next-generation parametrised resource allocator for out-of-order pipeline resources: physical registers, RS/ROB/LSQ slots.
- Grants up to NUM_REQUESTS free resources per cycle in a deterministic compacted order and reports free count.
- Supports all-or-nothing or partial grant modes.
- Keeps NUM_CKPT branch checkpoints of the free pool; a mispredict restore squashes every allocation made after the checkpoint in one cycle.

---
 rtl/ckpt_allocator.sv | 111 +++++++++++
 1 files changed

// File: rtl/ckpt_allocator.sv
// Free-pool allocator with compacted multi-grant and branch checkpoints.
// Grants come combinationally from the registered pool; restore rebuilds the pool from a snapshot.
module ckpt_allocator #(
    parameter int                       NUM_RESOURCES = 64,
    parameter int                       NUM_REQUESTS  = 3,
    parameter int                       NUM_CKPT      = 4,
    parameter bit                       ATOMIC        = 1'b1,
    parameter logic [NUM_RESOURCES-1:0] RESET_FREE    = '1,
    localparam int                      CW            = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1,
    localparam int                      FCW           = $clog2(NUM_RESOURCES + 1)
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic [NUM_REQUESTS-1:0]                      req,
    input  logic [NUM_RESOURCES-1:0]                     clear,
    input  logic                                         ckpt_save,
    input  logic [CW-1:0]                                ckpt_save_id,
    input  logic                                         ckpt_restore,
    input  logic [CW-1:0]                                ckpt_restore_id,
    output logic [NUM_REQUESTS-1:0][NUM_RESOURCES-1:0]   grant,
    output logic [NUM_REQUESTS-1:0]                      grant_valid,
    output logic                                         stall,
    output logic [NUM_RESOURCES-1:0]                     free_mask,
    output logic [FCW-1:0]                               free_count
);

    logic [NUM_RESOURCES-1:0] status_q, status_d;
    logic [NUM_RESOURCES-1:0] snap_q  [NUM_CKPT];
    logic [NUM_RESOURCES-1:0] snap_d  [NUM_CKPT];
    logic [NUM_RESOURCES-1:0] freed_q [NUM_CKPT];
    logic [NUM_RESOURCES-1:0] freed_d [NUM_CKPT];

    logic [NUM_RESOURCES-1:0]                    avail;
    logic [NUM_REQUESTS-1:0][NUM_RESOURCES-1:0]  cand;
    logic [NUM_RESOURCES-1:0]                    alloc;
    logic [NUM_RESOURCES-1:0]                    restore_img;
    logic                                        grant_ok;
    logic                                        save_en;
    int unsigned                                 n_req;
    int unsigned                                 n_free;

    // Each asserted requester peels the lowest remaining free bit, giving compacted order.
    always_comb begin
        avail  = status_q;
        cand   = '0;
        n_req  = 0;
        n_free = 0;
        for (int r = 0; r < NUM_RESOURCES; r++) begin
            if (status_q[r]) n_free++;
        end
        for (int i = 0; i < NUM_REQUESTS; i++) begin
            if (req[i]) begin
                cand[i] = avail & (~avail + NUM_RESOURCES'(1));
                avail   = avail & ~cand[i];
                n_req++;
            end
        end

        grant_ok = !reset && !ckpt_restore;
        if (ATOMIC && (n_req > n_free)) grant_ok = 1'b0;

        grant       = '0;
        grant_valid = '0;
        alloc       = '0;
        for (int i = 0; i < NUM_REQUESTS; i++) begin
            grant_valid[i] = grant_ok && req[i] && (cand[i] != '0);
            if (grant_valid[i]) grant[i] = cand[i];
            alloc = alloc | grant[i];
        end
        stall      = |(req & ~grant_valid);
        free_mask  = status_q;
        free_count = FCW'(n_free);
    end

    // Restore beats save; every slot except a freshly saved one accumulates this cycle's clears.
    always_comb begin
        save_en     = ckpt_save && !ckpt_restore;
        restore_img = '0;
        if (int'(ckpt_restore_id) < NUM_CKPT)
            restore_img = snap_q[ckpt_restore_id] | freed_q[ckpt_restore_id];

        status_d = (status_q & ~alloc) | clear;
        if (ckpt_restore) status_d = restore_img | clear;

        for (int j = 0; j < NUM_CKPT; j++) begin
            snap_d[j]  = snap_q[j];
            freed_d[j] = freed_q[j] | clear;
            if (save_en && (int'(ckpt_save_id) == j)) begin
                snap_d[j]  = status_d;
                freed_d[j] = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            status_q <= RESET_FREE;
            for (int j = 0; j < NUM_CKPT; j++) begin
                snap_q[j]  <= RESET_FREE;
                freed_q[j] <= '0;
            end
        end else begin
            status_q <= status_d;
            for (int j = 0; j < NUM_CKPT; j++) begin
                snap_q[j]  <= snap_d[j];
                freed_q[j] <= freed_d[j];
            end
        end
    end

endmodule
